// File: rtl/prime_pkg.sv
// Shared types for the prime collector: widths, FIFO entry layout and
// the collector's control states.
package prime_pkg;

  localparam int DATA_W = 11;

  typedef struct packed {
    logic [DATA_W-1:0] prime;
    logic [DATA_W-1:0] gap;
  } prime_entry_t;

  typedef enum logic {
    EMPTY_HIST = 1'b0,
    TRACKING   = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/prime_fifo.sv
// Generic synchronous FIFO with push/pop, separate occupancy counter and
// a combinational head read at the read pointer.
module prime_fifo #(
  parameter  int W     = 22,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_din,
  output logic [W-1:0]     o_dout,
  output logic [PTR_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr && !rst) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/prime_collector.sv
// Captures primes from the sweep checker with their gap to the previous
// prime, queues them for a valid/ready consumer and keeps statistics.
module prime_collector
  import prime_pkg::*;
#(
  parameter  int DATA_W = prime_pkg::DATA_W,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_number,
  input  logic              in_is_prime,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_prime,
  output logic [DATA_W-1:0] out_gap,
  output logic [PTR_W:0]    fifo_count,
  output logic [DATA_W-1:0] last_prime,
  output logic [DATA_W-1:0] max_gap,
  output logic              overflow,
  output logic              seq_err
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;

  logic [DATA_W-1:0] r_last;
  logic [DATA_W-1:0] r_max;
  logic              r_ovf;
  logic              r_seq;

  logic              w_cand;
  logic              w_order_bad;
  logic              w_accept;
  logic [DATA_W-1:0] w_gap;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [2*DATA_W-1:0] w_head;

  assign w_cand      = in_valid && in_is_prime;
  assign w_order_bad = (r_state == TRACKING) && (in_number <= r_last);
  assign w_accept    = w_cand && !w_order_bad;
  assign w_gap       = (r_state == TRACKING) ? in_number - r_last : '0;
  assign w_pop       = out_valid && out_ready;
  assign w_drop      = w_accept && w_full && !w_pop;

  prime_fifo #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   ({in_number, w_gap}),
    .o_dout  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Stale storage is masked so an empty FIFO presents zeros.
  assign out_valid  = !w_empty;
  assign out_prime  = out_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
  assign out_gap    = out_valid ? w_head[DATA_W-1:0] : '0;
  assign last_prime = r_last;
  assign max_gap    = r_max;
  assign overflow   = r_ovf;
  assign seq_err    = r_seq;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY_HIST: if (w_accept) w_state_nxt = TRACKING;
      TRACKING:   w_state_nxt = TRACKING;
      default:    w_state_nxt = EMPTY_HIST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY_HIST;
    end else if (clr) begin
      r_state <= EMPTY_HIST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
      r_max  <= '0;
      r_ovf  <= 1'b0;
      r_seq  <= 1'b0;
    end else if (clr) begin
      r_last <= '0;
      r_max  <= '0;
      r_ovf  <= 1'b0;
      r_seq  <= 1'b0;
    end else begin
      unique case (1'b1)
        w_accept: begin
          r_last <= in_number;
          if (w_gap > r_max) r_max <= w_gap;
          if (w_drop) r_ovf <= 1'b1;
        end
        (w_cand && w_order_bad): r_seq <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_collector.sv
// Scoreboard bench for prime_collector: directed scenarios plus a
// randomized sweep checked against a queue-based reference model.
module tb_prime_collector;
  import prime_pkg::*;

  localparam int DW  = 11;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_number = '0;
  logic          in_is_prime = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_prime;
  logic [DW-1:0] out_gap;
  logic [4:0]    fifo_count;
  logic [DW-1:0] last_prime;
  logic [DW-1:0] max_gap;
  logic          overflow;
  logic          seq_err;

  prime_collector #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_number   (in_number),
    .in_is_prime (in_is_prime),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_prime   (out_prime),
    .out_gap     (out_gap),
    .fifo_count  (fifo_count),
    .last_prime  (last_prime),
    .max_gap     (max_gap),
    .overflow    (overflow),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  prime_entry_t exp_q[$];
  int m_cnt  = 0;
  int m_last = 0;
  int m_max  = 0;
  bit m_have = 0;
  bit m_ovf  = 0;
  bit m_seq  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0; m_last = 0; m_max = 0;
    m_have = 0; m_ovf = 0; m_seq = 0;
  endtask

  // Monitor: compares the presented head, consumes it on a handshake.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        check("head", 32'({out_prime, out_gap}), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input int n, input bit p, input bit r);
    bit pop;
    int gap;
    in_valid    = v;
    in_number   = DW'(n);
    in_is_prime = p;
    out_ready   = r;
    pop = (m_cnt != 0) && r;
    if (v && p) begin
      if (m_have && n <= m_last) begin
        m_seq = 1;
      end else begin
        gap = m_have ? n - m_last : 0;
        if (m_cnt < DEP || pop) begin
          exp_q.push_back('{prime: DW'(n), gap: DW'(gap)});
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
        m_last = n;
        m_have = 1;
        if (gap > m_max) m_max = gap;
      end
    end
    if (pop) m_cnt--;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, r);
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(m_cnt));
    check({tag, "_last"},  32'(last_prime), 32'(m_last));
    check({tag, "_max"},   32'(max_gap),    32'(m_max));
    check({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, "_seq"},   32'(seq_err),    32'(m_seq));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_cnt != 0; i++) step(0, 0, 0, 1);
    check("drained", 32'(m_cnt), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    bit v, p, r;

    #12;
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_prime", 32'(out_prime), 32'd0);
    check("rst_gap",   32'(out_gap),   32'd0);
    check_stats("rst");

    // Basic capture
    step(1, 2, 1, 1);
    step(1, 3, 1, 1);
    step(1, 5, 1, 1);
    step(1, 7, 1, 1);
    step(1, 9, 0, 1);
    idle(3, 1);
    check("basic_last", 32'(last_prime), 32'd7);
    check("basic_max",  32'(max_gap),    32'd2);
    check("basic_cnt",  32'(fifo_count), 32'd0);
    check_stats("basic");

    // Backpressure and stability
    do_clr();
    check_stats("clr");
    step(1, 11, 1, 0);
    step(1, 13, 1, 0);
    step(1, 17, 1, 0);
    idle(4, 0);
    check("bp_cnt", 32'(fifo_count), 32'd3);
    check("bp_head", 32'({out_prime, out_gap}), 32'({11'd11, 11'd0}));
    drain();
    check("bp_max", 32'(max_gap), 32'd4);

    // Full and overflow
    do_clr();
    for (int i = 0; i < 17; i++) step(1, 100 + i, 1, 0);
    check("full_cnt",  32'(fifo_count), 32'd16);
    check("full_ovf",  32'(overflow),   32'd1);
    check("full_last", 32'(last_prime), 32'd116);
    step(1, 120, 1, 1);
    check("fullpp_cnt", 32'(fifo_count), 32'd16);
    check("fullpp_ovf", 32'(overflow),   32'd1);
    check_stats("full");
    drain();

    // Ordering fault
    do_clr();
    step(1, 20, 1, 1);
    step(1, 23, 1, 1);
    step(1, 19, 1, 1);
    idle(2, 1);
    check("ord_seq",  32'(seq_err),    32'd1);
    check("ord_last", 32'(last_prime), 32'd23);
    check("ord_max",  32'(max_gap),    32'd3);
    check_stats("ord");

    // Gap tracking
    do_clr();
    step(1, 113, 1, 0);
    step(1, 127, 1, 0);
    check("gap_max", 32'(max_gap), 32'd14);
    step(0, 0, 0, 1);
    check("gap_head", 32'({out_prime, out_gap}), 32'({11'd127, 11'd14}));
    drain();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 200 + 3 * i, 1, 0);
    check("pre_rst_cnt", 32'(fifo_count), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid),  32'd0);
    check("arst_cnt",   32'(fifo_count), 32'd0);
    check("arst_last",  32'(last_prime), 32'd0);
    check("arst_max",   32'(max_gap),    32'd0);
    check("arst_flags", 32'({overflow, seq_err}), 32'd0);
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1, 2, 1, 0);
    check("post_rst_head", 32'({out_prime, out_gap}), 32'({11'd2, 11'd0}));
    drain();

    // Randomized sweep
    do_clr();
    base = 2;
    for (int i = 0; i < 600; i++) begin
      if (base > 1900) begin
        drain();
        check_stats("rand_wrap");
        do_clr();
        base = $urandom_range(2, 50);
      end
      v = ($urandom % 4) != 0;
      p = ($urandom % 2) != 0;
      r = ($urandom % 3) != 0;
      if (($urandom % 12) == 0 && base > 6) begin
        n = base - $urandom_range(0, 5);
      end else begin
        base += $urandom_range(1, 20);
        n = base;
      end
      step(v, n, p, r);
      if (i % 50 == 0) check_stats("rand");
    end
    drain();
    check_stats("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
